// File: rtl/s1_weight_loader.sv
// Weight+CRC vector loader for the TMR layer-1 neuron: streams M ROM words into Wcrc and refetches on CRC error.
// Optional build macro WLOAD_ERRCNT_EN adds err_cnt, a saturating count of CRC-fail events since reset.
module s1_weight_loader #(
  parameter int M        = 8,
  parameter int n        = 16,
  parameter int cl       = 8,
  parameter int ADDRW    = 8,
  parameter int MAXRETRY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDRW-1:0]              base_addr,
  output logic                          mem_rd,
  output logic [ADDRW-1:0]              mem_addr,
  input  logic [n+cl-1:0]               mem_rdata,
  input  logic                          rfflag,
  output logic [M*(n+cl)-1:0]           Wcrc,
  output logic                          wvalid,
  output logic                          busy,
  output logic                          fail,
`ifdef WLOAD_ERRCNT_EN
  output logic [15:0]                   err_cnt,
`endif
  output logic [$clog2(MAXRETRY+1)-1:0] retry_cnt
);

  localparam int WW = n + cl;
  localparam int RW = $clog2(MAXRETRY + 1);
  localparam int IW = $clog2(M + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_SETTLE, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t              r_state;
  logic [ADDRW-1:0]    r_base;
  logic [ADDRW-1:0]    r_mem_addr;
  logic                r_mem_rd;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       r_rd_idx;
  logic                r_rd_p1;
  logic [IW-1:0]       r_cap_idx_p1;
  logic [M*WW-1:0]     r_wcrc;
  logic                r_wvalid;
  logic                r_busy;
  logic                r_fail;
  logic [RW-1:0]       r_retry;
  logic                w_err;

  // rfflag only matters once Wcrc is complete and stable
  assign w_err = rfflag && (r_state == S_CHECK || r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_idx        <= '0;
      r_rd_idx     <= '0;
      r_rd_p1      <= 1'b0;
      r_cap_idx_p1 <= '0;
      r_wcrc       <= '0;
      r_wvalid     <= 1'b0;
      r_busy       <= 1'b0;
      r_fail       <= 1'b0;
      r_retry      <= '0;
    end else begin
      // read stage: ROM returns data one cycle after the strobe
      r_rd_p1      <= r_mem_rd;
      r_cap_idx_p1 <= r_rd_idx;
      // capture stage: slot i gets the data of read i
      if (r_rd_p1) begin
        for (int i = 0; i < M; i++) begin
          if (r_cap_idx_p1 == IW'(i)) r_wcrc[i*WW +: WW] <= mem_rdata;
        end
      end

      if (w_err) begin
        r_wvalid <= 1'b0;
        if (r_retry < RW'(MAXRETRY)) begin
          r_retry <= r_retry + 1'b1;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_state <= S_FETCH;
        end else begin
          r_fail  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_FAIL;
        end
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
              r_base   <= base_addr;
              r_retry  <= '0;
              r_fail   <= 1'b0;
              r_wvalid <= 1'b0;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (r_idx == IW'(M)) begin
              r_mem_rd <= 1'b0;
              r_state  <= S_DRAIN;
            end else begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_base + ADDRW'(r_idx);
              r_rd_idx   <= r_idx;
              r_idx      <= r_idx + 1'b1;
            end
          end
          S_DRAIN:  r_state <= S_SETTLE;
          S_SETTLE: r_state <= S_CHECK;
          S_CHECK: begin
            r_wvalid <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef WLOAD_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign Wcrc      = r_wcrc;
  assign wvalid    = r_wvalid;
  assign busy      = r_busy;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_s1_weight_loader.sv
// Bench for s1_weight_loader: ROM model, checksum-based neuron rfflag model, read-address scoreboard.
module tb_s1_weight_loader;

  localparam int M = 8;
  localparam int N = 16;
  localparam int CL = 8;
  localparam int ADDRW = 8;
  localparam int MAXRETRY = 3;
  localparam int WW = N + CL;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDRW-1:0]  base_addr;
  logic              mem_rd;
  logic [ADDRW-1:0]  mem_addr;
  logic [WW-1:0]     mem_rdata = '0;
  logic              rfflag;
  logic [M*WW-1:0]   Wcrc;
  logic              wvalid;
  logic              busy;
  logic              fail;
  logic [1:0]        retry_cnt;
`ifdef WLOAD_ERRCNT_EN
  logic [15:0]       err_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  logic [WW-1:0]     rom [256];
  bit                transient_mode;
  int                rd10_cnt = 0;
  int                rd10_mark;
  logic              force_err;
  logic [ADDRW-1:0]  exp_q [$];

  always #5 clk = ~clk;

  s1_weight_loader #(.M(M), .n(N), .cl(CL), .ADDRW(ADDRW), .MAXRETRY(MAXRETRY)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rfflag    (rfflag),
    .Wcrc      (Wcrc),
    .wvalid    (wvalid),
    .busy      (busy),
    .fail      (fail),
`ifdef WLOAD_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .retry_cnt (retry_cnt)
  );

  // Stand-in CRC: low byte is the XOR of the two weight bytes
  function automatic logic [WW-1:0] mkword(logic [15:0] w);
    return {w, w[15:8] ^ w[7:0]};
  endfunction

  function automatic logic crc_bad(logic [M*WW-1:0] v);
    logic [WW-1:0] wd;
    for (int i = 0; i < M; i++) begin
      wd = v[i*WW +: WW];
      if (wd[7:0] != (wd[23:16] ^ wd[15:8])) return 1'b1;
    end
    return 1'b0;
  endfunction

  assign rfflag = crc_bad(Wcrc) | force_err;

  // Synchronous ROM; optionally corrupts the first read of 0x10 after arming
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= rom[mem_addr];
      if (mem_addr == 8'h10) begin
        rd10_cnt <= rd10_cnt + 1;
        if (transient_mode && rd10_cnt == rd10_mark) mem_rdata <= rom[8'h10] ^ 24'h010000;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && mem_rd) begin
      if (exp_q.size() == 0) chk("sb_extra_rd", 64'(exp_q.size()), 64'd1);
      else chk("rd_addr", 64'(mem_addr), 64'(exp_q.pop_front()));
    end
  end

  task automatic push_pass(input logic [ADDRW-1:0] b, input int passes);
    logic [ADDRW-1:0] a;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < M; i++) begin
        a = b + ADDRW'(i);
        exp_q.push_back(a);
      end
  endtask

  // Returns #1 after the edge that samples start (edge 0)
  task automatic launch(input logic [ADDRW-1:0] b);
    @(posedge clk); #1;
    base_addr = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) chk("load_timeout", 64'(busy), 64'd0);
  endtask

  task automatic chk_image(input logic [ADDRW-1:0] b);
    logic [ADDRW-1:0] a;
    for (int i = 0; i < M; i++) begin
      a = b + ADDRW'(i);
      chk($sformatf("wcrc_w%0d", i), 64'(Wcrc[i*WW +: WW]), 64'(rom[a]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    logic [WW-1:0] good17;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    force_err = 1'b0;
    transient_mode = 1'b0;
    rd10_mark = 0;
    for (int a = 0; a < 256; a++) rom[a] = mkword(16'($urandom));

    #3;
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_retry", 64'(retry_cnt), 64'd0);
    chk("rst_wcrc_zero", 64'(Wcrc == '0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // clean load
    push_pass(8'h10, 1);
    launch(8'h10);
    chk("s1_busy", 64'(busy), 64'd1);
    run_load(cyc);
    chk("s1_latency", 64'(cyc), 64'd12);
    chk("s1_wvalid", 64'(wvalid), 64'd1);
    chk("s1_retry", 64'(retry_cnt), 64'd0);
    chk_image(8'h10);
    chk("s1_sb_drained", 64'(exp_q.size()), 64'd0);

    // transient error on the first read of word 0
    rd10_mark = rd10_cnt;
    transient_mode = 1'b1;
    push_pass(8'h10, 2);
    launch(8'h10);
    run_load(cyc);
    transient_mode = 1'b0;
    chk("s2_latency", 64'(cyc), 64'd24);
    chk("s2_wvalid", 64'(wvalid), 64'd1);
    chk("s2_retry", 64'(retry_cnt), 64'd1);
    chk("s2_fail", 64'(fail), 64'd0);
    chk_image(8'h10);
    chk("s2_sb_drained", 64'(exp_q.size()), 64'd0);

    // persistent error exhausts retries
    do_reset();
    good17 = rom[8'h17];
    rom[8'h17] = good17 ^ 24'h000001;
    push_pass(8'h10, 1 + MAXRETRY);
    launch(8'h10);
    run_load(cyc);
    chk("s3_latency", 64'(cyc), 64'(12 * (1 + MAXRETRY)));
    chk("s3_fail", 64'(fail), 64'd1);
    chk("s3_wvalid", 64'(wvalid), 64'd0);
    chk("s3_busy", 64'(busy), 64'd0);
    chk("s3_retry", 64'(retry_cnt), 64'd3);
    chk("s3_held_bad", 64'(Wcrc[7*WW +: WW]), 64'(good17 ^ 24'h000001));
`ifdef WLOAD_ERRCNT_EN
    chk("s3_err_cnt", 64'(err_cnt), 64'd4);
`endif
    chk("s3_sb_drained", 64'(exp_q.size()), 64'd0);
    rom[8'h17] = good17;

    // address wrap, start ignored while busy, fail cleared by start
    push_pass(8'hFC, 1);
    launch(8'hFC);
    chk("s4_fail_clr", 64'(fail), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    base_addr = 8'h40;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_load(cyc);
    chk("s4_wvalid", 64'(wvalid), 64'd1);
    chk("s4_retry", 64'(retry_cnt), 64'd0);
    chk_image(8'hFC);
    chk("s4_sb_drained", 64'(exp_q.size()), 64'd0);

    // register upset while in DONE
    push_pass(8'hFC, 1);
    @(posedge clk); #1;
    force_err = 1'b1;
    @(posedge clk); #1;
    force_err = 1'b0;
    chk("s5_wvalid_drop", 64'(wvalid), 64'd0);
    chk("s5_busy", 64'(busy), 64'd1);
    run_load(cyc);
    chk("s5_latency", 64'(cyc), 64'd12);
    chk("s5_wvalid", 64'(wvalid), 64'd1);
    chk("s5_retry", 64'(retry_cnt), 64'd1);
    chk("s5_sb_drained", 64'(exp_q.size()), 64'd0);

    // async reset mid-fetch
    push_pass(8'h20, 1);
    launch(8'h20);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_mem_rd", 64'(mem_rd), 64'd0);
    chk("ar_mem_addr", 64'(mem_addr), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_wvalid", 64'(wvalid), 64'd0);
    chk("ar_retry", 64'(retry_cnt), 64'd0);
    chk("ar_wcrc_zero", 64'(Wcrc == '0), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_discard", 64'(Wcrc == '0), 64'd1);
    chk("ar_idle_busy", 64'(busy), 64'd0);
    chk("ar_idle_rd", 64'(mem_rd), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
